// File: rtl/ifetch_fill_unit.sv
// ifetch_fill_unit
// Instruction-cache refill engine sitting directly upstream of Fetch.
// On a Fetch miss it latches the missing line address, reads the four words
// of the line from word-wide instruction memory (one request outstanding at a
// time), assembles the 128-bit line and writes it into Fetch's I-cache with a
// single-cycle WiCache strobe. A Fetch redirect (abort) cancels a fill; if a
// memory read is already in flight its response is drained and dropped.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   ICacheMiss(_tag)    level miss indication and 5-bit line address
//   abort               Fetch redirect, cancels a fill in progress
//   memReq/memAddr      word read request, address {tag, wordIdx}
//   memAck              request accepted on memReq & memAck edge
//   memRespValid/Data   in-order read data, one per accepted request
//   WiCache             one-cycle I-cache write strobe
//   WiCacheline         filled line, word k at [32k+31:32k]
//   WiCachetag          zero-extended tag of the filled line
//   fillBusy            high whenever a fill (or drain) is in progress
module ifetch_fill_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ICacheMiss,
    input  logic [4:0]        ICacheMiss_tag,
    input  logic              abort,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic              memRespValid,
    input  logic [31:0]       memRespData,
    output logic              WiCache,
    output logic [127:0]      WiCacheline,
    output logic [8:0]        WiCachetag,
    output logic              fillBusy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        tag_q, tag_d;       // tag of the fill in progress
    logic [1:0]        widx_q, widx_d;     // word currently being fetched
    logic [2:0][31:0]  wbuf_q, wbuf_d;     // words 0..2 collected so far
    // Output line/tag live in their own registers so they keep the last
    // completed fill even while a later fill (or an aborted one) is running.
    logic [127:0]      line_q, line_d;
    logic [4:0]        otag_q, otag_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            widx_q  <= '0;
            wbuf_q  <= '0;
            line_q  <= '0;
            otag_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            widx_q  <= widx_d;
            wbuf_q  <= wbuf_d;
            line_q  <= line_d;
            otag_q  <= otag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        widx_d  = widx_q;
        wbuf_d  = wbuf_q;
        line_d  = line_q;
        otag_d  = otag_q;
        unique case (state_q)
            S_IDLE: begin
                if (ICacheMiss) begin
                    tag_d   = ICacheMiss_tag;
                    widx_d  = 2'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // An accepted request must have its response consumed even
                // when Fetch redirects on the same edge.
                if (abort)       state_d = memAck ? S_DRAIN : S_IDLE;
                else if (memAck) state_d = S_RESP;
            end
            S_RESP: begin
                if (memRespValid) begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (widx_q == 2'd3) begin
                        line_d  = {memRespData, wbuf_q[2], wbuf_q[1], wbuf_q[0]};
                        otag_d  = tag_q;
                        state_d = S_DONE;
                    end else begin
                        wbuf_d[widx_q] = memRespData;
                        widx_d         = widx_q + 2'd1;
                        state_d        = S_REQ;
                    end
                end else if (abort) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (memRespValid) state_d = S_IDLE;
            end
            S_DONE:  state_d = S_HOLD;
            // The cache write lands at the end of DONE; the miss Fetch is
            // still showing here is stale, so skip one cycle before IDLE.
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        memAddr      = '0;
        memAddr[6:0] = {tag_q, widx_q};
    end

    assign memReq      = (state_q == S_REQ);
    assign WiCache     = (state_q == S_DONE);
    assign WiCacheline = line_q;
    assign WiCachetag  = {4'd0, otag_q};
    assign fillBusy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ifetch_fill_unit.sv
module tb_ifetch_fill_unit;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset, ICacheMiss, abort, memAck, memRespValid;
    logic [4:0]        tag_in;
    logic [31:0]       memRespData;
    logic              memReq, WiCache, fillBusy;
    logic [ADDR_W-1:0] memAddr;
    logic [127:0]      WiCacheline;
    logic [8:0]        WiCachetag;

    ifetch_fill_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .ICacheMiss(ICacheMiss), .ICacheMiss_tag(tag_in),
        .abort(abort), .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
        .memRespValid(memRespValid), .memRespData(memRespData), .WiCache(WiCache),
        .WiCacheline(WiCacheline), .WiCachetag(WiCachetag), .fillBusy(fillBusy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0, chks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        chks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [4:0]   tag;
        logic [127:0] line;
    } fill_t;
    fill_t             exp_fill[$];
    logic [ADDR_W-1:0] exp_addr[$];

    // Memory returns 0xA0000000 | word address; the line is words tag*4+0..3.
    function automatic logic [127:0] ref_line(input logic [4:0] t);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hA000_0000 | 32'(int'(t) * 4 + k);
        return l;
    endfunction

    task automatic push_addrs(input logic [4:0] t, input int n);
        for (int k = 0; k < n; k++) exp_addr.push_back(ADDR_W'(int'(t) * 4 + k));
    endtask

    task automatic expect_fill(input logic [4:0] t);
        fill_t f;
        f.tag  = t;
        f.line = ref_line(t);
        exp_fill.push_back(f);
        push_addrs(t, 4);
    endtask

    // ---------------- memory model ----------------
    int          ack_delay = 0, resp_delay = 1, wait_cnt = 0, pend_rem = 0, hs_cnt = 0;
    bit          rand_mem = 1'b0, pend = 1'b0;
    logic [31:0] pend_data = '0;

    initial begin
        memAck = 1'b0; memRespValid = 1'b0; memRespData = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else if (memReq && memAck) begin
                hs_cnt++;
                pend      = 1'b1;
                pend_rem  = resp_delay;
                pend_data = 32'hA000_0000 | 32'(memAddr);
                wait_cnt  = 0;
                if (rand_mem) begin
                    ack_delay  = $urandom_range(0, 3);
                    resp_delay = $urandom_range(1, 3);
                end
            end
            @(posedge clk); #1;
            memRespValid = 1'b0;
            memAck       = 1'b0;
            if (pend && !reset) begin
                pend_rem--;
                if (pend_rem == 0) begin
                    memRespValid = 1'b1;
                    memRespData  = pend_data;
                    pend         = 1'b0;
                end
            end
            if (memReq && !reset) begin
                memAck = (wait_cnt >= ack_delay);
                wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic              pr_req = 1'b0, pr_ack = 1'b0, pr_wic = 1'b0;
    logic [ADDR_W-1:0] pr_addr = '0;

    initial begin
        fill_t f;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (memReq && pr_req && !pr_ack) chk("addr_stable", 128'(memAddr), 128'(pr_addr));
                if (memReq && memAck) begin
                    if (exp_addr.size() == 0) begin
                        chks++; errs++;
                        $display("FAIL unexpected_req addr=%0d", memAddr);
                    end else begin
                        chk("memAddr", 128'(memAddr), 128'(exp_addr.pop_front()));
                    end
                end
                if (WiCache) begin
                    chki("wic_single", int'(pr_wic), 0);
                    if (exp_fill.size() == 0) begin
                        chks++; errs++;
                        $display("FAIL unexpected_wicache tag=%0d", WiCachetag);
                    end else begin
                        f = exp_fill.pop_front();
                        chk("line", WiCacheline, f.line);
                        chk("tag", 128'(WiCachetag), 128'({4'd0, f.tag}));
                    end
                end
            end
            pr_req  = memReq;
            pr_ack  = memAck;
            pr_addr = memAddr;
            pr_wic  = WiCache;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue a miss and follow it to the write strobe; exp_lat<0 skips latency.
    task automatic run_fill(input logic [4:0] t, input int exp_lat, input bit hold_after);
        int n0;
        bit seen;
        expect_fill(t);
        ICacheMiss = 1'b1;
        tag_in     = t;
        n0         = cyc;
        seen       = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            tag_in = 5'($urandom);  // must be ignored while busy
            if (WiCache) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chks++; errs++;
            $display("FAIL wicache_timeout tag=%0d", t);
        end else if (exp_lat >= 0) begin
            chki("latency", cyc - n0, exp_lat);
        end
        ICacheMiss = hold_after;
        tick();
        chki("wic_low_hold", int'(WiCache), 0);
        chki("busy_hold", int'(fillBusy), 1);
        ICacheMiss = 1'b0;
        tick();
        chki("busy_idle", int'(fillBusy), 0);
    endtask

    task automatic wait_hs(input int target, input string nm);
        for (int i = 0; i < 200 && hs_cnt < target; i++) tick();
        if (hs_cnt < target) begin
            chks++; errs++;
            $display("FAIL %s_timeout hs=%0d want=%0d", nm, hs_cnt, target);
        end
    endtask

    initial begin
        int base;
        reset = 1'b1; ICacheMiss = 1'b0; tag_in = '0; abort = 1'b0;
        repeat (2) tick();
        chki("rst_memReq", int'(memReq), 0);
        chk("rst_memAddr", 128'(memAddr), 128'd0);
        chki("rst_wic", int'(WiCache), 0);
        chk("rst_line", WiCacheline, 128'd0);
        chk("rst_tag", 128'(WiCachetag), 128'd0);
        chki("rst_busy", int'(fillBusy), 0);
        reset = 1'b0;
        tick();

        // 1: immediate ack, response next cycle
        ack_delay = 0; resp_delay = 1;
        run_fill(5'd3, 9, 1'b0);
        chk("line_held", WiCacheline, ref_line(5'd3));

        // 2: ack delayed 3 cycles per request
        ack_delay = 3;
        run_fill(5'd3, 21, 1'b0);
        ack_delay = 0;

        // 3: abort in RESP of word 1, response 2 cycles later -> drained
        resp_delay = 3;
        push_addrs(5'd3, 2);
        base = hs_cnt;
        ICacheMiss = 1'b1; tag_in = 5'd3;
        wait_hs(base + 2, "t3");
        abort = 1'b1; ICacheMiss = 1'b0;
        tick();
        abort = 1'b0;
        chki("t3_drain_busy", int'(fillBusy), 1);
        chki("t3_drain_req", int'(memReq), 0);
        tick();
        chki("t3_drain_busy2", int'(fillBusy), 1);
        tick();
        chki("t3_idle", int'(fillBusy), 0);
        chk("t3_line_kept", WiCacheline, ref_line(5'd3));
        resp_delay = 1;
        run_fill(5'd7, 9, 1'b0);

        // 4: miss held through WiCache and HOLD -> only one fill
        run_fill(5'd12, 9, 1'b1);
        base = hs_cnt;
        repeat (12) tick();
        chki("t4_no_refill", hs_cnt, base);
        chki("t4_idle", int'(fillBusy), 0);

        // 6: abort in REQ with no ack -> no traffic
        ack_delay = 50;
        base = hs_cnt;
        ICacheMiss = 1'b1; tag_in = 5'd9;
        tick();
        chki("t6_req", int'(memReq), 1);
        abort = 1'b1; ICacheMiss = 1'b0;
        tick();
        abort = 1'b0;
        chki("t6_req_drop", int'(memReq), 0);
        chki("t6_idle", int'(fillBusy), 0);
        repeat (6) tick();
        chki("t6_no_traffic", hs_cnt, base);
        ack_delay = 0;

        // 5: reset in RESP of word 2
        resp_delay = 2;
        push_addrs(5'd3, 3);
        base = hs_cnt;
        ICacheMiss = 1'b1; tag_in = 5'd3;
        wait_hs(base + 3, "t5");
        reset = 1'b1; ICacheMiss = 1'b0;
        tick();
        chki("t5_memReq", int'(memReq), 0);
        chk("t5_memAddr", 128'(memAddr), 128'd0);
        chki("t5_wic", int'(WiCache), 0);
        chk("t5_line", WiCacheline, 128'd0);
        chk("t5_tag", 128'(WiCachetag), 128'd0);
        chki("t5_busy", int'(fillBusy), 0);
        reset = 1'b0;
        resp_delay = 1;
        tick();
        run_fill(5'd31, 9, 1'b0);

        // randomized memory timing, tags and idle gaps
        rand_mem = 1'b1;
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            run_fill(5'($urandom), -1, 1'($urandom_range(0, 1)));
        end
        rand_mem = 1'b0;

        repeat (8) tick();
        chki("fills_left", exp_fill.size(), 0);
        chki("addrs_left", exp_addr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
